// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared definitions for the SPI slave: synchronizer depth,
//               SPI mode encodings ({CPOL,CPHA}) and the frame state type.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Depth of the metastability synchronizer on each SPI pin.
  localparam int SYNC_STAGES = 2;

  // SPI modes encoded as {CPOL, CPHA}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_if
// Description : SPI pins plus the local word-exchange bus of the SPI slave.
//   SPI side   : sclk, cs_n, mosi (to slave); miso, miso_oe (from slave)
//   Local side : tx_data/tx_valid (to slave), tx_ready (from slave),
//                rx_data/rx_valid, tx_underrun, busy (from slave)
//   Modports   : slave  - the SPI slave block
//                master - the SPI master plus local logic driving the slave
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_if #(
  parameter int DATA_W = 8
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_underrun;
  logic              busy;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_sync
// Description : Brings sclk, cs_n and mosi into the clk domain and derives
//               one-clk sclk edge pulses (leading/trailing relative to CPOL)
//               and chip-select edge pulses.
//   clk, rst   : system clock, asynchronous active-low reset
//   sclk/cs_n/mosi : raw asynchronous SPI pins
//   lead_edge  : sclk moved away from its idle level (gated by cs_n)
//   trail_edge : sclk returned to its idle level (gated by cs_n)
//   cs_fall    : synchronized cs_n went low
//   cs_rise    : synchronized cs_n went high
//   mosi_s     : synchronized mosi, aligned with the sclk edge pulses
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter bit CPOL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic lead_edge,
  output logic trail_edge,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_ff;
  logic [SYNC_STAGES-1:0] cs_ff;
  logic [SYNC_STAGES-1:0] mosi_ff;
  logic                   sclk_d;
  logic                   cs_d;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   sclk_chg;

  // Reset to the idle bus state so releasing reset never fakes an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_ff <= {SYNC_STAGES{CPOL}};
      cs_ff   <= '1;
      mosi_ff <= '0;
      sclk_d  <= CPOL;
      cs_d    <= 1'b1;
    end else begin
      sclk_ff <= {sclk_ff[SYNC_STAGES-2:0], sclk};
      cs_ff   <= {cs_ff[SYNC_STAGES-2:0], cs_n};
      mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], mosi};
      sclk_d  <= sclk_ff[SYNC_STAGES-1];
      cs_d    <= cs_ff[SYNC_STAGES-1];
    end
  end

  assign sclk_s   = sclk_ff[SYNC_STAGES-1];
  assign cs_s     = cs_ff[SYNC_STAGES-1];
  assign mosi_s   = mosi_ff[SYNC_STAGES-1];
  assign sclk_chg = (sclk_s != sclk_d) && !cs_s;

  assign lead_edge  = sclk_chg && (sclk_s != CPOL);
  assign trail_edge = sclk_chg && (sclk_s == CPOL);
  assign cs_fall    = cs_d && !cs_s;
  assign cs_rise    = !cs_d && cs_s;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave
// Description : SPI slave with CPOL/CPHA selection. Receives MSB-first words
//               on mosi, transmits words from a single-entry TX buffer on
//               miso, and reports each received word with a one-clk pulse.
//   clk, rst   : system clock (>= 4x sclk), asynchronous active-low reset
//   bus        : spi_slave_if.slave - SPI pins and local TX/RX word bus
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave
  import spi_pkg::*;
#(
  parameter bit CPOL   = 1'b1,
  parameter bit CPHA   = 1'b1,
  parameter int DATA_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  spi_slave_if.slave  bus
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [1:0]       MODE     = {CPOL, CPHA};
  // Modes 1 and 3 sample mosi on the trailing sclk edge.
  localparam bit SAMPLE_ON_TRAIL = (MODE == MODE1) || (MODE == MODE3);

  logic lead_edge, trail_edge, cs_fall, cs_rise, mosi_s;

  spi_slave_sync #(
    .CPOL (CPOL)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .sclk       (bus.sclk),
    .cs_n       (bus.cs_n),
    .mosi       (bus.mosi),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise),
    .mosi_s     (mosi_s)
  );

  state_t            state, state_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] rx_shreg;
  logic [DATA_W-1:0] tx_shreg;
  logic [DATA_W-1:0] tx_buf;
  logic              tx_full;
  logic              first;
  logic              miso_oe;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_underrun;

  logic              frame_start, frame_end;
  logic              sample, shift, reload, clr_first;
  logic              load, word_done, handshake;
  logic [DATA_W-1:0] rx_word;

  // --------------------------------------------------------------------------
  // Frame state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = ACTIVE;
      ACTIVE:  if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Edge decode: which sclk edge samples, which shifts, when a word reloads
  // --------------------------------------------------------------------------
  always_comb begin
    sample    = 1'b0;
    shift     = 1'b0;
    reload    = 1'b0;
    clr_first = 1'b0;
    // A cs_n rise wins over any edge in the same clk: the frame is ending.
    if (state == ACTIVE && !cs_rise) begin
      if (SAMPLE_ON_TRAIL) begin
        sample    = trail_edge;
        // The first leading edge of a word keeps the MSB already on miso.
        shift     = lead_edge && !first;
        clr_first = lead_edge && first;
        reload    = trail_edge && (bit_cnt == CNT_LAST);
      end else begin
        sample    = lead_edge;
        shift     = trail_edge && (bit_cnt != CNT_FULL);
        reload    = trail_edge && (bit_cnt == CNT_FULL);
      end
    end
  end

  assign frame_start = (state == IDLE) && cs_fall;
  assign frame_end   = (state == ACTIVE) && cs_rise;
  assign load        = frame_start || reload;
  assign word_done   = sample && (bit_cnt == CNT_LAST);
  assign rx_word     = {rx_shreg, mosi_s};
  assign handshake   = bus.tx_valid && !tx_full;

  // --------------------------------------------------------------------------
  // Datapath: TX buffer, shift registers, bit counter, status pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt     <= '0;
      rx_shreg    <= '0;
      tx_shreg    <= '0;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      first       <= 1'b0;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= word_done;
      // A load always sees the buffer as it was before this clk's handshake.
      tx_underrun <= load && !tx_full;

      if (word_done) rx_data <= rx_word;

      if (handshake) begin
        tx_buf  <= bus.tx_data;
        tx_full <= 1'b1;
      end else if (load) begin
        tx_full <= 1'b0;
      end

      if (load)           tx_shreg <= tx_full ? tx_buf : '0;
      else if (frame_end) tx_shreg <= '0;
      else if (shift)     tx_shreg <= {tx_shreg[DATA_W-2:0], 1'b0};

      if (frame_start)    rx_shreg <= '0;
      else if (sample)    rx_shreg <= rx_word[DATA_W-2:0];

      if (load || frame_end) bit_cnt <= '0;
      else if (sample)       bit_cnt <= bit_cnt + CNT_W'(1);

      if (load)           first <= 1'b1;
      else if (clr_first) first <= 1'b0;

      if (frame_start)    miso_oe <= 1'b1;
      else if (frame_end) miso_oe <= 1'b0;
    end
  end

  assign bus.miso        = tx_shreg[DATA_W-1];
  assign bus.miso_oe     = miso_oe;
  assign bus.tx_ready    = !tx_full;
  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.tx_underrun = tx_underrun;
  assign bus.busy        = (state == ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave
// Description : Testbench for spi_slave. Drives one SPI master waveform into
//               two slaves (mode 3 and mode 0) at sclk = clk/8, with mosi
//               timed for each mode, and compares miso words, received
//               words, underrun pulses and status against a word-level model
//               of the TX buffer and frame rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;
  import spi_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sclk_line = 1'b0;   // 1 = away from idle level
  logic         cs_line = 1'b1;
  logic         mosi_m0 = 1'b0;     // valid before the leading edge
  logic         mosi_m1 = 1'b0;     // changes on the leading edge
  logic         tx_valid = 1'b0;
  logic [W-1:0] tx_data = '0;

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_W(W)) b3 ();
  spi_slave_if #(.DATA_W(W)) b0 ();

  assign b3.sclk     = ~sclk_line;
  assign b3.cs_n     = cs_line;
  assign b3.mosi     = mosi_m1;
  assign b3.tx_data  = tx_data;
  assign b3.tx_valid = tx_valid;
  assign b0.sclk     = sclk_line;
  assign b0.cs_n     = cs_line;
  assign b0.mosi     = mosi_m0;
  assign b0.tx_data  = tx_data;
  assign b0.tx_valid = tx_valid;

  spi_slave #(.CPOL(1'b1), .CPHA(1'b1), .DATA_W(W)) dut3 (.clk(clk), .rst(rst), .bus(b3));
  spi_slave #(.CPOL(1'b0), .CPHA(1'b0), .DATA_W(W)) dut0 (.clk(clk), .rst(rst), .bus(b0));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Observed pulses
  logic [W-1:0] rxq3[$];
  logic [W-1:0] rxq0[$];
  int urun3 = 0;
  int urun0 = 0;

  always @(negedge clk) begin
    if (b3.rx_valid)    rxq3.push_back(b3.rx_data);
    if (b0.rx_valid)    rxq0.push_back(b0.rx_data);
    if (b3.tx_underrun) urun3++;
    if (b0.tx_underrun) urun0++;
  end

  // Word-level reference model
  bit           mdl_full = 1'b0;
  logic [W-1:0] mdl_buf = '0;
  logic [W-1:0] mdl_last_rx = '0;
  logic [W-1:0] exp_rx[$];
  int           exp_urun = 0;

  logic [W-1:0] f_mosi[4];
  bit           f_push[4];
  logic [W-1:0] f_pval[4];

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mdl_reload(output logic [W-1:0] word);
    if (mdl_full) begin
      word     = mdl_buf;
      mdl_full = 1'b0;
    end else begin
      word = '0;
      exp_urun++;
    end
  endtask

  task automatic push_both(input logic [W-1:0] v);
    check("tx_ready3", b3.tx_ready, !mdl_full);
    check("tx_ready0", b0.tx_ready, !mdl_full);
    tx_data  = v;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
    mdl_full = 1'b1;
    mdl_buf  = v;
  endtask

  task automatic check_reset_vals();
    check("rst_miso3", b3.miso, 0);        check("rst_miso0", b0.miso, 0);
    check("rst_oe3", b3.miso_oe, 0);       check("rst_oe0", b0.miso_oe, 0);
    check("rst_txrdy3", b3.tx_ready, 1);   check("rst_txrdy0", b0.tx_ready, 1);
    check("rst_rxd3", b3.rx_data, 0);      check("rst_rxd0", b0.rx_data, 0);
    check("rst_rxv3", b3.rx_valid, 0);     check("rst_rxv0", b0.rx_valid, 0);
    check("rst_urun3", b3.tx_underrun, 0); check("rst_urun0", b0.tx_underrun, 0);
    check("rst_busy3", b3.busy, 0);        check("rst_busy0", b0.busy, 0);
  endtask

  task automatic compare_rx();
    check("rx_cnt3", rxq3.size(), exp_rx.size());
    check("rx_cnt0", rxq0.size(), exp_rx.size());
    foreach (exp_rx[i]) begin
      if (i < rxq3.size()) check("rx_word3", rxq3[i], exp_rx[i]);
      if (i < rxq0.size()) check("rx_word0", rxq0[i], exp_rx[i]);
    end
    rxq3.delete();
    rxq0.delete();
    exp_rx.delete();
    check("rx_hold3", b3.rx_data, mdl_last_rx);
    check("rx_hold0", b0.rx_data, mdl_last_rx);
    check("underruns3", urun3, exp_urun);
    check("underruns0", urun0, exp_urun);
  endtask

  // One cs_n frame of nw words. cut > 0 ends the frame after that many bits;
  // rst_abort ends it with a reset instead of a cs_n rise.
  task automatic run_frame(input int nw, input int cut, input bit rst_abort);
    logic [W-1:0] cur, got0, got3;
    int  bits    = 0;
    bit  aborted = 1'b0;
    mdl_reload(cur);
    cs_line = 1'b0;
    mosi_m0 = f_mosi[0][W-1];
    wait_clk(6);
    check("busy3", b3.busy, 1);      check("busy0", b0.busy, 1);
    check("oe3", b3.miso_oe, 1);     check("oe0", b0.miso_oe, 1);
    check("txrdy_fall3", b3.tx_ready, !mdl_full);
    check("txrdy_fall0", b0.tx_ready, !mdl_full);
    for (int w = 0; w < nw && !aborted; w++) begin
      got0 = '0;
      got3 = '0;
      for (int b = W - 1; b >= 0; b--) begin
        if (cut > 0 && bits == cut) begin
          aborted = 1'b1;
          break;
        end
        mosi_m0 = f_mosi[w][b];
        if (!(w == 0 && b == W - 1)) wait_clk(4);
        got0[b]   = b0.miso;
        sclk_line = 1'b1;
        mosi_m1   = f_mosi[w][b];
        if (b == W - 4 && f_push[w] && !mdl_full) begin
          push_both(f_pval[w]);
          wait_clk(3);
        end else begin
          wait_clk(4);
        end
        got3[b]   = b3.miso;
        sclk_line = 1'b0;
        bits++;
      end
      if (!aborted) begin
        check("miso_word0", got0, cur);
        check("miso_word3", got3, cur);
        exp_rx.push_back(f_mosi[w]);
        mdl_last_rx = f_mosi[w];
        mdl_reload(cur);
      end
    end
    wait_clk(4);
    compare_rx();
    if (rst_abort) begin
      rst = 1'b0;
      #1;
      check_reset_vals();
      cs_line   = 1'b1;
      sclk_line = 1'b0;
      mosi_m0   = 1'b0;
      mosi_m1   = 1'b0;
      wait_clk(2);
      rst = 1'b1;
      wait_clk(2);
      mdl_full    = 1'b0;
      mdl_last_rx = '0;
    end else begin
      cs_line = 1'b1;
      wait_clk(3);
      check("end_busy3", b3.busy, 0);    check("end_busy0", b0.busy, 0);
      check("end_oe3", b3.miso_oe, 0);   check("end_oe0", b0.miso_oe, 0);
      check("end_miso3", b3.miso, 0);    check("end_miso0", b0.miso, 0);
      wait_clk(3);
      check("idle_txrdy3", b3.tx_ready, !mdl_full);
      check("idle_txrdy0", b0.tx_ready, !mdl_full);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 4; i++) begin
      f_mosi[i] = '0;
      f_push[i] = 1'b0;
      f_pval[i] = '0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wait_clk(3);
    check_reset_vals();
    rst = 1'b1;
    wait_clk(2);

    // Single word, mode 3 and mode 0 views
    clear_frame(); push_both(8'hA5); f_mosi[0] = 8'h3C; run_frame(1, 0, 0);
    clear_frame(); push_both(8'h81); f_mosi[0] = 8'hFF; run_frame(1, 0, 0);

    // Two words, buffer refilled during each word
    clear_frame(); push_both(8'hC3);
    f_mosi[0] = 8'h11; f_push[0] = 1'b1; f_pval[0] = 8'h12;
    f_mosi[1] = 8'h22; f_push[1] = 1'b1; f_pval[1] = 8'h56;
    run_frame(2, 0, 0);

    // Empty buffer at frame start
    clear_frame(); f_mosi[0] = 8'h96; run_frame(1, 0, 0);

    // Frame cut after 5 bits, then a clean frame
    clear_frame(); push_both(8'h77); f_mosi[0] = 8'hE1; run_frame(1, 5, 0);
    clear_frame(); push_both(8'h2D); f_mosi[0] = 8'h4B; run_frame(1, 0, 0);

    // Reset mid-frame, then a clean frame
    clear_frame(); push_both(8'h99); f_mosi[0] = 8'h0F; run_frame(1, 3, 1);
    clear_frame(); push_both(8'h6E); f_mosi[0] = 8'h5A; run_frame(1, 0, 0);

    // Randomized frames
    for (int n = 0; n < 24; n++) begin
      int nw;
      int cut;
      clear_frame();
      nw = int'($urandom_range(1, 3));
      for (int i = 0; i < nw; i++) begin
        f_mosi[i] = W'($urandom);
        f_push[i] = 1'($urandom_range(0, 1));
        f_pval[i] = W'($urandom);
      end
      if ($urandom_range(0, 1) == 1 && !mdl_full) push_both(W'($urandom));
      cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, nw * W - 1)) : 0;
      run_frame(nw, cut, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
